cpu_mul_pipe: RTL

//   Parametrised pipelined integer multiplier for the execute stage; replaces the fixed 5-deep

---
 rtl/cpu_mul_pipe.sv | 110 +++++++++++
 1 files changed

// File: rtl/cpu_mul_pipe.sv
// Pipelined integer multiplier for the execute stage: one op per cycle, low/high-half and
// signed modes, stall/flush/backpressure, and a per-stage destination view for hazard checks.
module cpu_mul_pipe #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned NUM_REGS   = 32,
    parameter int unsigned MUL_STAGES = 5,
    localparam int unsigned RegIdW    = $clog2(NUM_REGS),
    localparam int unsigned CntW      = $clog2(MUL_STAGES + 1)
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         in_valid_i,
    output logic                         in_ready_o,
    input  logic [RegIdW-1:0]            in_rd_id_i,
    input  logic [DATA_WIDTH-1:0]        in_op_a_i,
    input  logic [DATA_WIDTH-1:0]        in_op_b_i,
    input  logic [1:0]                   in_mode_i,
    input  logic                         stall_i,
    input  logic                         flush_i,
    output logic                         wb_valid_o,
    input  logic                         wb_ready_i,
    output logic [RegIdW-1:0]            wb_rd_id_o,
    output logic [DATA_WIDTH-1:0]        wb_result_o,
    output logic [MUL_STAGES-1:0]        stage_valid_o,
    output logic [MUL_STAGES*RegIdW-1:0] stage_rd_id_o,
    output logic [NUM_REGS-1:0]          rd_pending_o,
    output logic [CntW-1:0]              inflight_o
);

    localparam int unsigned W    = DATA_WIDTH;
    localparam int unsigned Last = MUL_STAGES - 1;

    logic [MUL_STAGES-1:0] valid_q, valid_d;
    logic [RegIdW-1:0]     rd_q  [MUL_STAGES];
    logic [RegIdW-1:0]     rd_d  [MUL_STAGES];
    logic [W-1:0]          res_q [MUL_STAGES];
    logic [W-1:0]          res_d [MUL_STAGES];

    logic           advance;
    logic           a_signed, b_signed;
    logic [2*W-1:0] a_ext, b_ext, prod;
    logic [W-1:0]   mul_res;

    assign advance    = !stall_i && (!valid_q[Last] || wb_ready_i);
    assign in_ready_o = advance;

    // Full product is formed at entry so every stage, including the last, holds a registered
    // result; the downstream stages are plain delay for retiming to spread the multiplier over.
    always_comb begin
        a_signed = (in_mode_i == 2'd1) || (in_mode_i == 2'd2);
        b_signed = (in_mode_i == 2'd1);
        a_ext    = {{W{a_signed & in_op_a_i[W-1]}}, in_op_a_i};
        b_ext    = {{W{b_signed & in_op_b_i[W-1]}}, in_op_b_i};
        prod     = a_ext * b_ext;
        mul_res  = (in_mode_i == 2'd0) ? prod[W-1:0] : prod[2*W-1:W];
    end

    always_comb begin
        valid_d = valid_q;
        rd_d    = rd_q;
        res_d   = res_q;
        if (advance) begin
            valid_d[0] = in_valid_i;
            rd_d[0]    = in_rd_id_i;
            res_d[0]   = mul_res;
            for (int unsigned i = 1; i < MUL_STAGES; i++) begin
                valid_d[i] = valid_q[i-1];
                rd_d[i]    = rd_q[i-1];
                res_d[i]   = res_q[i-1];
            end
        end
        // Flush wins over stall and over the incoming request.
        if (flush_i) begin
            valid_d = '0;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            valid_q <= '0;
            for (int unsigned i = 0; i < MUL_STAGES; i++) begin
                rd_q[i]  <= '0;
                res_q[i] <= '0;
            end
        end else begin
            valid_q <= valid_d;
            rd_q    <= rd_d;
            res_q   <= res_d;
        end
    end

    assign wb_valid_o    = valid_q[Last];
    assign wb_rd_id_o    = rd_q[Last];
    assign wb_result_o   = res_q[Last];
    assign stage_valid_o = valid_q;

    always_comb begin
        stage_rd_id_o = '0;
        rd_pending_o  = '0;
        inflight_o    = '0;
        for (int unsigned i = 0; i < MUL_STAGES; i++) begin
            stage_rd_id_o[i*RegIdW +: RegIdW] = rd_q[i];
            if (valid_q[i]) begin
                rd_pending_o[rd_q[i]] = 1'b1;
                inflight_o            = inflight_o + CntW'(1);
            end
        end
    end

endmodule
